// File: rtl/pulse_pkg.sv
// Shared types for pulse-credit consumers: FSM state encoding
// and default credit counter width.
package pulse_pkg;

  localparam int CNT_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/pulse_credit_counter.sv
// Saturating up/down credit counter with sticky overflow flag.
// Ports: clk, rst (async, active-high), pulse (credit request),
//   dec (consume one), cnt/cnt_nxt (current/next count), sat, ovf.
module pulse_credit_counter
  import pulse_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pulse,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_nxt,
  output logic             sat,
  output logic             ovf
);

  logic inc;

  assign sat = (cnt == {CNT_W{1'b1}});
  // A pulse at saturation is dropped even if a credit
  // is consumed in the same cycle.
  assign inc = pulse && !sat;

  always_comb begin
    cnt_nxt = cnt;
    unique case (1'b1)
      (inc && !dec): cnt_nxt = cnt + 1'b1;
      (dec && !inc): cnt_nxt = cnt - 1'b1;
      default:       cnt_nxt = cnt;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      if (pulse && sat)
        ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/pulse_credit_dispatcher.sv
// Counts incoming single-cycle pulses as credits and dispenses them
// as valid/ready events. Optional macro PULSE_DISPATCH_GAP_EN forces
// GAP_CYCLES idle cycles between consecutive events.
// Ports: clk, rst (async, active-high), pulse_in, evt_valid,
//   evt_ready, credit_cnt, ovf (sticky drop flag), busy.
module pulse_credit_dispatcher
  import pulse_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int GAP_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pulse_in,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [CNT_W-1:0] credit_cnt,
  output logic             ovf,
  output logic             busy
);

  if (GAP_CYCLES < 1 || GAP_CYCLES > 255) begin : g_bad_gap
    $error("GAP_CYCLES must be within 1..255");
  end

  state_t           state;
  logic             hs;
  logic             sat;
  logic [CNT_W-1:0] cnt_nxt;

  assign hs   = evt_valid && evt_ready;
  assign busy = (credit_cnt != '0) || evt_valid;

  pulse_credit_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .pulse   (pulse_in),
    .dec     (hs),
    .cnt     (credit_cnt),
    .cnt_nxt (cnt_nxt),
    .sat     (sat),
    .ovf     (ovf)
  );

`ifdef PULSE_DISPATCH_GAP_EN
  logic [7:0] gap_cnt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      evt_valid <= 1'b0;
`ifdef PULSE_DISPATCH_GAP_EN
      gap_cnt   <= 8'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (credit_cnt != '0) begin
            state     <= OFFER;
            evt_valid <= 1'b1;
          end
        end
        OFFER: begin
          if (hs) begin
`ifdef PULSE_DISPATCH_GAP_EN
            state     <= GAP;
            evt_valid <= 1'b0;
            gap_cnt   <= 8'(GAP_CYCLES);
`else
            // Back-to-back offer when credit remains after this one.
            if (cnt_nxt == '0) begin
              state     <= IDLE;
              evt_valid <= 1'b0;
            end
`endif
          end
        end
`ifdef PULSE_DISPATCH_GAP_EN
        GAP: begin
          gap_cnt <= gap_cnt - 8'd1;
          if (gap_cnt == 8'd1) begin
            if (cnt_nxt != '0) begin
              state     <= OFFER;
              evt_valid <= 1'b1;
            end else begin
              state     <= IDLE;
            end
          end
        end
`endif
        default: begin
          state     <= IDLE;
          evt_valid <= 1'b0;
        end
      endcase
    end
  end

  // sat is consumed inside the counter; kept visible for debug.
  logic unused_sat;
  assign unused_sat = sat;

endmodule
